// File: rtl/disp_sched.sv
// Display scheduler: picks one of four 16-bit debug sources for the 4-digit display.
// Optional DISP_SCHED_TAG_EN replaces the top digit with the source number.
module disp_sched #(
    parameter int DEB_W   = 16,
    parameter int DWELL_W = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] src0,
    input  logic [15:0] src1,
    input  logic [15:0] src2,
    input  logic [15:0] src3,
    input  logic [3:0]  src_valid,
    input  logic        btn_next,
    input  logic        auto_en,
    input  logic        freeze,
    output logic [15:0] digit,
    output logic [1:0]  page,
    output logic [3:0]  page_led
);

    typedef enum logic [1:0] {MANUAL, AUTO, HOLD} state_t;

    state_t             state;
    state_t             state_next;
    logic               btn_s0;
    logic               btn_s1;
    logic               deb_lvl;
    logic [DEB_W-1:0]   deb_cnt;
    logic [DWELL_W-1:0] dwell;
    logic               next_pulse;
    logic               dwell_done;
    logic               page_lost;
    logic               want_adv;
    logic               page_chg;
    logic               found;
    logic [1:0]         target;
    logic [15:0]        src_sel;

    // Synchronizer plus debounce; the level only moves after a full counter run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s0  <= 1'b0;
            btn_s1  <= 1'b0;
            deb_lvl <= 1'b0;
            deb_cnt <= '0;
        end else begin
            btn_s0 <= btn_next;
            btn_s1 <= btn_s0;
            if (btn_s1 == deb_lvl) begin
                deb_cnt <= '0;
            end else if (&deb_cnt) begin
                deb_lvl <= btn_s1;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // Fires on the same edge the debounced level rises.
    assign next_pulse = btn_s1 & ~deb_lvl & (&deb_cnt);

    // The mode decoded from this cycle's inputs governs this edge's actions.
    always_comb begin
        state_next = MANUAL;
        if (freeze) begin
            state_next = HOLD;
        end else if (auto_en) begin
            state_next = AUTO;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MANUAL;
        end else begin
            state <= state_next;
        end
    end

    // Upward search with wrap for the next requester wanting display time.
    always_comb begin
        target = page;
        found  = 1'b0;
        for (int i = 1; i < 4; i++) begin
            if (!found && src_valid[page + 2'(i)]) begin
                target = page + 2'(i);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        src_sel = src0;
        case (page)
            2'd0: src_sel = src0;
            2'd1: src_sel = src1;
            2'd2: src_sel = src2;
            2'd3: src_sel = src3;
            default: src_sel = src0;
        endcase
    end

    assign dwell_done = (state_next == AUTO) && (&dwell);
    assign page_lost  = !src_valid[page] && (|src_valid);
    assign want_adv   = (state_next != HOLD) && (next_pulse || dwell_done || page_lost);
    assign page_chg   = want_adv && found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            page  <= 2'd0;
            dwell <= '0;
        end else begin
            if (page_chg) begin
                page <= target;
            end
            // Cleared outside AUTO, on the entry edge, and on every page move.
            if (state_next != AUTO || state != AUTO || page_chg) begin
                dwell <= '0;
            end else begin
                dwell <= dwell + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit <= 16'h0000;
        end else if (state_next != HOLD) begin
            if (!src_valid[page]) begin
                digit <= 16'h0000;
            end else begin
`ifdef DISP_SCHED_TAG_EN
                digit <= {2'b00, page, src_sel[11:0]};
`else
                digit <= src_sel;
`endif
            end
        end
    end

    assign page_led = 4'b0001 << page;

endmodule

// File: tb/tb_disp_sched.sv
// Directed bench for disp_sched: expected page moves are queued by the stimulus
// and checked by a monitor whenever the page output changes.
`timescale 1ns/1ps
module tb_disp_sched;

    localparam int DEB_W   = 2;
    localparam int DWELL_W = 4;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic [15:0] src0      = 16'h1111;
    logic [15:0] src1      = 16'h2222;
    logic [15:0] src2      = 16'h3333;
    logic [15:0] src3      = 16'h4444;
    logic [3:0]  src_valid = 4'b1111;
    logic        btn_next  = 1'b0;
    logic        auto_en   = 1'b0;
    logic        freeze    = 1'b0;
    logic [15:0] digit;
    logic [1:0]  page;
    logic [3:0]  page_led;

    int tests        = 0;
    int fails        = 0;
    int cyc          = 0;
    int chg_cnt      = 0;
    int chg_cyc      = 0;
    int prev_chg_cyc = 0;
    int c0           = 0;
    int t0           = 0;

    logic [17:0] exp_q[$];
    logic [17:0] mon_e;
    logic [1:0]  last_page = 2'd0;
    logic        dig_pend  = 1'b0;
    logic [15:0] dig_exp   = 16'h0000;

    disp_sched #(.DEB_W(DEB_W), .DWELL_W(DWELL_W)) dut (
        .clk(clk), .rst(rst),
        .src0(src0), .src1(src1), .src2(src2), .src3(src3),
        .src_valid(src_valid), .btn_next(btn_next),
        .auto_en(auto_en), .freeze(freeze),
        .digit(digit), .page(page), .page_led(page_led)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [3:0] onehot(input logic [1:0] p);
        case (p)
            2'd0: return 4'b0001;
            2'd1: return 4'b0010;
            2'd2: return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every page move must match the head of the expected queue,
    // and the new source must reach digit one edge later.
    always @(negedge clk) begin
        if (rst) begin
            dig_pend = 1'b0;
        end else if (page != last_page) begin
            chg_cnt++;
            prev_chg_cyc = chg_cyc;
            chg_cyc      = cyc;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_page_change: got page %0d, expected no change", page);
            end else begin
                mon_e = exp_q.pop_front();
                check("page", 32'(page), 32'(mon_e[17:16]));
                check("page_led", 32'(page_led), 32'(onehot(mon_e[17:16])));
                dig_exp  = mon_e[15:0];
                dig_pend = 1'b1;
            end
        end else if (dig_pend) begin
            check("digit_after_change", 32'(digit), 32'(dig_exp));
            dig_pend = 1'b0;
        end
        last_page = page;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int n);
        btn_next = 1'b1;
        tick(n);
        btn_next = 1'b0;
        tick(10);
    endtask

    task automatic expect_page(input logic [1:0] p, input logic [15:0] d);
        exp_q.push_back({p, d});
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s: got %0d page changes still pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state, observed without any clock edge.
        #2 rst = 1'b1;
        #1;
        check("reset_page", 32'(page), 32'd0);
        check("reset_page_led", 32'(page_led), 32'(4'b0001));
        check("reset_digit", 32'(digit), 32'h0000);
        tick(2);
        rst = 1'b0;
        tick(2);
        check("post_reset_digit", 32'(digit), 32'h1111);

        // Held button gives one advance; short glitch gives none.
        c0 = chg_cnt;
        expect_page(2'd1, 16'h2222);
        press(6);
        wait_empty("hold_press", 20);
        check("hold_one_advance", 32'(chg_cnt - c0), 32'd1);
        c0 = chg_cnt;
        press(2);
        check("glitch_page", 32'(page), 32'd1);
        check("glitch_no_advance", 32'(chg_cnt - c0), 32'd0);

        // Skip invalid sources and wrap; a lone valid page stays put.
        src_valid = 4'b1010;
        expect_page(2'd3, 16'h4444);
        press(6);
        wait_empty("skip_press", 20);
        expect_page(2'd1, 16'h2222);
        press(6);
        wait_empty("wrap_press", 20);
        src_valid = 4'b0010;
        c0 = chg_cnt;
        press(6);
        check("single_valid_page", 32'(page), 32'd1);
        check("single_valid_no_advance", 32'(chg_cnt - c0), 32'd0);

        // Auto rotation every 16 cycles, restarted by a manual press.
        src_valid = 4'b1111;
        auto_en   = 1'b1;
        expect_page(2'd2, 16'h3333);
        expect_page(2'd3, 16'h4444);
        expect_page(2'd0, 16'h1111);
        wait_empty("auto_steps", 70);
        check("auto_interval", 32'(chg_cyc - prev_chg_cyc), 32'd16);
        tick(5);
        expect_page(2'd1, 16'h2222);
        expect_page(2'd2, 16'h3333);
        press(6);
        wait_empty("auto_after_press", 40);
        check("auto_interval_after_press", 32'(chg_cyc - prev_chg_cyc), 32'd16);

        // Freeze holds page and digit through source changes and presses.
        freeze  = 1'b1;
        auto_en = 1'b0;
        tick(2);
        src2 = 16'hBEEF;
        c0 = chg_cnt;
        press(6);
        check("freeze_digit", 32'(digit), 32'h3333);
        check("freeze_page", 32'(page), 32'd2);
        check("freeze_no_advance", 32'(chg_cnt - c0), 32'd0);
        freeze = 1'b0;
        tick(1);
        check("unfreeze_digit", 32'(digit), 32'hBEEF);

        // Invalidated page moves on the very next edge.
        src_valid = 4'b1011;
        t0 = cyc;
        expect_page(2'd3, 16'h4444);
        wait_empty("invalidate", 10);
        check("invalidate_latency", 32'(chg_cyc - t0), 32'd1);
        tick(2);
        src_valid = 4'b0000;
        c0 = chg_cnt;
        tick(3);
        check("all_invalid_digit", 32'(digit), 32'h0000);
        check("all_invalid_page", 32'(page), 32'd3);
        check("all_invalid_no_advance", 32'(chg_cnt - c0), 32'd0);

        // Asynchronous reset mid-dwell with a press in the debouncer.
        src_valid = 4'b1111;
        auto_en   = 1'b1;
        tick(8);
        btn_next = 1'b1;
        tick(3);
        #2 rst = 1'b1;
        #1;
        check("async_reset_page", 32'(page), 32'd0);
        check("async_reset_page_led", 32'(page_led), 32'(4'b0001));
        check("async_reset_digit", 32'(digit), 32'h0000);
        btn_next = 1'b0;
        auto_en  = 1'b0;
        tick(2);
        rst = 1'b0;
        c0 = chg_cnt;
        tick(30);
        check("after_reset_page", 32'(page), 32'd0);
        check("after_reset_no_advance", 32'(chg_cnt - c0), 32'd0);
        check("after_reset_digit", 32'(digit), 32'h1111);

        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL leftover_expectations: got %0d, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
